cntrl_pulse_dispatch: RTL and testbench
=======================================

Name: cntrl_pulse_dispatch

Overview:
- Command dispatcher sitting between the host command byte stream and N pulse-sequencer channel controllers that share one 8-bit cmd_data bus.
- Buffers a 5-byte host frame, decodes the target channel, then drives that channel's mask bit and the shared bus with the fixed 6-cycle channel load protocol.
- Monitors the channel's data_ack and reports protocol faults; one frame in flight at a time.

Parameters:
- N_CHANNELS, 4, number of channel controllers served (1..16).
- WAIT_LIMIT, 255, max cycles to wait for the target channel's data_ack to drop before dropping the frame.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  host frame byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  dispatcher accepts in_data this cycle (transfer = in_valid & in_ready).
- cmd_data  output  8  shared channel command bus.
- mask  output  N_CHANNELS  one-hot per-channel load strobe.
- data_ack  input  N_CHANNELS  per-channel "reading bus" indication.
- busy  output  1  frame buffered or being issued.
- err_clear  input  1  clears sticky error flags.
- err_bad_chan  output  1  sticky: frame addressed channel >= N_CHANNELS.
- err_no_ack  output  1  sticky: target data_ack wrong during burst.
- err_timeout  output  1  sticky: target never went idle within WAIT_LIMIT.
- frame_count  output  16  frames issued successfully, wraps 0xFFFF->0.

Behaviour:
- Reset (async): state COLLECT, byte index 0, in_ready=1, cmd_data=0, mask=0, busy=0, all err flags=0, frame_count=0.
- Frame format: byte0 = {chan[7:4], setting[3:0]}; bytes1..4 = 32-bit value, MSB first.
- COLLECT:
  - in_ready=1; each transfer stores the byte at the current index.
  - After byte4 is stored, go to CHECK. busy=1 from the first accepted byte.
- CHECK (1 cycle, in_ready=0):
  - chan >= N_CHANNELS: set err_bad_chan, drop the frame, go to COLLECT.
  - Otherwise go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay while data_ack[chan]=1, counting cycles.
  - When data_ack[chan]=0, go to STROBE.
  - If the count reaches WAIT_LIMIT, set err_timeout, drop the frame, go to COLLECT.
- Burst, fixed and never stalled (cycle T = STROBE):
  - T: mask[chan]=1, cmd_data=0.
  - T+1..T+4: cmd_data = value[31:24], [23:16], [15:8], [7:0].
  - T+5: cmd_data = {4'b0, setting}.
  - T+6: back to COLLECT; cmd_data=0 and mask=0 outside STROBE.
- Ack check:
  - data_ack[chan] must be 1 in each of T+1..T+5.
  - Any 0 sets err_no_ack; the burst still completes, and frame_count does not increment for that frame.
  - Otherwise frame_count increments at T+5.
  - data_ack of non-target channels is ignored.
- in_ready=0 from CHECK through T+5. First byte of the next frame is accepted at T+6 at the earliest, so back-to-back frames take 12 cycles minimum.
- setting=0 is legal: the burst is issued as normal and the channel commits nothing.
- err_clear clears all sticky flags. If a set and a clear occur in the same cycle, set wins.
- Reset mid-burst: outputs return to reset values immediately and the partial frame is discarded. Channels recover on their own once mask stays low.
- All outputs are registered; no combinational path from in_valid or data_ack to any output.

Decomposition:
- Shared package cntrl_pkg:
  - state enum (COLLECT, CHECK, WAIT_IDLE, STROBE, B0, B1, B2, B3, SET);
  - FRAME_BYTES=5;
  - header field positions CHAN_MSB/LSB and SET_MSB/LSB.
- Sub-module cntrl_frame_buffer: 5-byte collect register with index counter and full flag. The dispatcher FSM stays in the top module.

Test Plan:
- Nominal load:
  - Stimulus: N=4, frame 0x2A,0xDE,0xAD,0xBE,0xEF, slave model acks T+1..T+5.
  - Response: mask=4'b0100 for one cycle, then cmd_data DE,AD,BE,EF,0A on consecutive cycles; frame_count=1; no errors.
- Bad channel:
  - Stimulus: header 0x51 with N=4.
  - Response: err_bad_chan=1, mask never asserted, frame_count unchanged, in_ready back high 1 cycle after CHECK.
- Busy channel and timeout:
  - Stimulus: data_ack[1] held 1 for 10 cycles.
  - Response: STROBE happens 10 cycles later.
  - Stimulus: data_ack[1] held 1 for 300 cycles with WAIT_LIMIT=255.
  - Response: err_timeout=1, no strobe.
- Missing ack:
  - Stimulus: slave drops data_ack at T+3.
  - Response: full burst still emitted, err_no_ack=1, frame_count unchanged; err_clear pulse returns the flag to 0.
- Host stalls and back-to-back frames:
  - Stimulus: in_valid gaps of 3 cycles between bytes, then two frames back-to-back.
  - Response: bytes captured correctly, second strobe exactly 12 cycles after the first when the host streams continuously.
- Reset mid-burst:
  - Stimulus: assert reset at T+2.
  - Response: mask=0 and cmd_data=0 in the same cycle (async), frame_count=0, a following frame loads normally.

Source files
------------

// File: rtl/cntrl_pkg.sv
// Shared types and frame layout for the pulse-sequencer command dispatcher.
package cntrl_pkg;

   typedef enum logic [3:0] {
      COLLECT,
      CHECK,
      WAIT_IDLE,
      STROBE,
      B0,
      B1,
      B2,
      B3,
      SET
   } state_t;

   localparam int FRAME_BYTES = 5;

   // Header byte layout: {chan, setting}
   localparam int CHAN_MSB = 7;
   localparam int CHAN_LSB = 4;
   localparam int SET_MSB  = 3;
   localparam int SET_LSB  = 0;

endpackage

// File: rtl/cntrl_frame_buffer.sv
// Collects one 5-byte host frame; holds it until the dispatcher clears it.
module cntrl_frame_buffer
   import cntrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        wr,
   input  logic        clear,
   input  logic [7:0]  data,
   output logic [7:0]  header,
   output logic [31:0] value,
   output logic        last,
   output logic        full,
   output logic        empty
);

   localparam int CW = $clog2(FRAME_BYTES + 1);

   logic [CW-1:0] count;
   logic [7:0]    bytes_q [FRAME_BYTES];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (wr && !full) begin
         count <= count + 1'b1;
      end
   end

   // NOTE: the byte store is deliberately not reset; count decides which bytes are meaningful.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FRAME_BYTES; i++) begin
         if (wr && count == CW'(i)) bytes_q[i] <= data;
      end
   end

   assign header = bytes_q[0];
   assign value  = {bytes_q[1], bytes_q[2], bytes_q[3], bytes_q[4]};
   assign last   = (count == CW'(FRAME_BYTES - 1));
   assign full   = (count == CW'(FRAME_BYTES));
   assign empty  = (count == '0);

endmodule

// File: rtl/cntrl_pulse_dispatch.sv
// Host frame dispatcher: buffers a frame, waits for the target channel to idle,
// then issues the fixed 6-cycle mask/cmd_data load burst and tracks data_ack.
module cntrl_pulse_dispatch
   import cntrl_pkg::*;
#(
   parameter int N_CHANNELS = 4,
   parameter int WAIT_LIMIT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [7:0]            cmd_data,
   output logic [N_CHANNELS-1:0] mask,
   input  logic [N_CHANNELS-1:0] data_ack,
   output logic                  busy,
   input  logic                  err_clear,
   output logic                  err_bad_chan,
   output logic                  err_no_ack,
   output logic                  err_timeout,
   output logic [15:0]           frame_count
);

   localparam int WW = $clog2(WAIT_LIMIT + 1);

   state_t                  state, next_state;
   logic [WW-1:0]           wait_cnt, wait_next;
   logic                    ack_ok, ack_ok_next;
   logic                    wr, clear, last, full, empty;
   logic [7:0]              header;
   logic [31:0]             value;
   logic [CHAN_MSB-CHAN_LSB:0] chan;
   logic [SET_MSB-SET_LSB:0]   setting;
   logic [N_CHANNELS-1:0]   sel;
   logic                    bad_chan, tgt_ack, in_burst;
   logic                    set_bad, set_timeout, set_no_ack, count_inc;
   logic                    busy_next;
   logic [7:0]              cmd_next;

   assign wr    = in_valid & in_ready;
   assign clear = (state != COLLECT) && (next_state == COLLECT);

   cntrl_frame_buffer u_buf (
      .clk    (clk),
      .reset  (reset),
      .wr     (wr),
      .clear  (clear),
      .data   (in_data),
      .header (header),
      .value  (value),
      .last   (last),
      .full   (full),
      .empty  (empty)
   );

   assign chan     = header[CHAN_MSB:CHAN_LSB];
   assign setting  = header[SET_MSB:SET_LSB];
   assign bad_chan = (int'(chan) >= N_CHANNELS);
   // An out-of-range channel shifts the strobe off the end, so sel is all zero.
   assign sel      = N_CHANNELS'(1) << chan;
   assign tgt_ack  = |(data_ack & sel);
   assign in_burst = state inside {B0, B1, B2, B3, SET};

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      next_state  = state;
      wait_next   = wait_cnt;
      ack_ok_next = ack_ok;
      set_bad     = 1'b0;
      set_timeout = 1'b0;
      set_no_ack  = 1'b0;
      count_inc   = 1'b0;
      case (state)
         COLLECT: if (wr && last) next_state = CHECK;
         CHECK: begin
            if (bad_chan || !full) begin
               set_bad    = bad_chan;
               next_state = COLLECT;
            end else if (tgt_ack) begin
               wait_next  = '0;
               next_state = WAIT_IDLE;
            end else begin
               next_state = STROBE;
            end
         end
         WAIT_IDLE: begin
            if (!tgt_ack) begin
               next_state = STROBE;
            end else if (wait_cnt == WW'(WAIT_LIMIT - 1)) begin
               set_timeout = 1'b1;
               next_state  = COLLECT;
            end else begin
               wait_next = wait_cnt + 1'b1;
            end
         end
         STROBE: begin
            ack_ok_next = 1'b1;
            next_state  = B0;
         end
         B0:  next_state = B1;
         B1:  next_state = B2;
         B2:  next_state = B3;
         B3:  next_state = SET;
         SET: begin
            count_inc  = ack_ok & tgt_ack;
            next_state = COLLECT;
         end
         default: next_state = COLLECT;
      endcase

      if (in_burst && !tgt_ack) begin
         set_no_ack  = 1'b1;
         ack_ok_next = 1'b0;
      end

      case (next_state)
         B0:      cmd_next = value[31:24];
         B1:      cmd_next = value[23:16];
         B2:      cmd_next = value[15:8];
         B3:      cmd_next = value[7:0];
         SET:     cmd_next = {4'b0, setting};
         default: cmd_next = 8'h00;
      endcase

      busy_next = (next_state != COLLECT) || (state == COLLECT && (wr || !empty));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= COLLECT;
         wait_cnt     <= '0;
         ack_ok       <= 1'b0;
         in_ready     <= 1'b1;
         cmd_data     <= 8'h00;
         mask         <= '0;
         busy         <= 1'b0;
         err_bad_chan <= 1'b0;
         err_no_ack   <= 1'b0;
         err_timeout  <= 1'b0;
         frame_count  <= 16'h0000;
      end else begin
         state        <= next_state;
         wait_cnt     <= wait_next;
         ack_ok       <= ack_ok_next;
         in_ready     <= (next_state == COLLECT);
         cmd_data     <= cmd_next;
         mask         <= (next_state == STROBE) ? sel : '0;
         busy         <= busy_next;
         // Sticky flags: a new event in the same cycle beats err_clear.
         err_bad_chan <= set_bad     | (err_bad_chan & ~err_clear);
         err_no_ack   <= set_no_ack  | (err_no_ack   & ~err_clear);
         err_timeout  <= set_timeout | (err_timeout  & ~err_clear);
         if (count_inc) frame_count <= frame_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_cntrl_pulse_dispatch.sv
// Directed bench for cntrl_pulse_dispatch with a burst scoreboard and a reactive channel model.
module tb_cntrl_pulse_dispatch;

   localparam int N  = 4;
   localparam int WL = 255;

   typedef struct packed {
      logic [N-1:0] mask;
      logic [39:0]  bytes;   // cmd_data expected at T+1..T+5, first byte in the top bits
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   cmd_data;
   logic [N-1:0] mask;
   logic [N-1:0] data_ack;
   logic         busy;
   logic         err_clear;
   logic         err_bad_chan;
   logic         err_no_ack;
   logic         err_timeout;
   logic [15:0]  frame_count;

   logic [N-1:0] slave_ack = '0;
   logic [N-1:0] force_ack = '0;
   int           drop_at   = 6;
   bit           mon_en    = 1'b1;
   int           cyc       = 0;
   int           checks    = 0;
   int           errors    = 0;
   exp_t         exp_q[$];
   int           strobe_cyc[$];

   assign data_ack = slave_ack | force_ack;

   cntrl_pulse_dispatch #(.N_CHANNELS(N), .WAIT_LIMIT(WL)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .cmd_data     (cmd_data),
      .mask         (mask),
      .data_ack     (data_ack),
      .busy         (busy),
      .err_clear    (err_clear),
      .err_bad_chan (err_bad_chan),
      .err_no_ack   (err_no_ack),
      .err_timeout  (err_timeout),
      .frame_count  (frame_count)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no completion, expected summary before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Channel model: on seeing its strobe, raises data_ack for T+1..T+5 (low from drop_at on).
   initial begin : slave
      int c;
      forever begin
         @(negedge clk);
         if (mask != '0) begin
            c = 0;
            for (int i = 0; i < N; i++) if (mask[i]) c = i;
            for (int k = 1; k <= 5; k++) begin
               @(posedge clk);
               #1;
               slave_ack[c] = (k < drop_at);
            end
            @(posedge clk);
            #1;
            slave_ack[c] = 1'b0;
         end
      end
   end

   // Scoreboard consumer: each strobe pops one expected burst and compares all six cycles.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && mask !== '0) begin
            strobe_cyc.push_back(cyc);
            check("strobe_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("strobe_mask", 32'(mask), 32'(e.mask));
               check("strobe_cmd_zero", 32'(cmd_data), 0);
               for (int k = 0; k < 5; k++) begin
                  @(negedge clk);
                  if (!mon_en) break;
                  check($sformatf("burst_byte%0d", k + 1), 32'(cmd_data), 32'(e.bytes[39-8*k -: 8]));
                  check($sformatf("burst_mask_low%0d", k + 1), 32'(mask), 0);
               end
            end
         end
      end
   end

   task automatic send_frame(input logic [39:0] f, input int gap, input bit expect_strobe);
      logic rdy;
      int   n;
      exp_t e;
      if (expect_strobe) begin
         e.mask  = N'(1) << f[39:36];
         e.bytes = {f[31:0], 4'b0, f[35:32]};
         exp_q.push_back(e);
      end
      for (int i = 0; i < 5; i++) begin
         in_data  = f[39-8*i -: 8];
         in_valid = 1'b1;
         n        = 0;
         forever begin
            @(negedge clk);
            rdy = in_ready;
            if (i > 0 && n == 0) check($sformatf("busy_mid_frame_b%0d", i), 32'(busy), 1);
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 400) begin
               check("in_ready_wait", 32'(rdy), 1);
               break;
            end
         end
         in_valid = 1'b0;
         if (i < 4) tick(gap);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy && in_ready) break;
         n++;
         if (n > 100) begin
            check("done_wait_busy", 32'(busy), 0);
            break;
         end
      end
      tick(1);
   endtask

   task automatic clear_pulse();
      err_clear = 1'b1;
      tick(1);
      err_clear = 1'b0;
   endtask

   initial begin : stimulus
      int c0;
      int n0;
      int n;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      err_clear = 1'b0;
      reset     = 1'b1;
      tick(3);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_cmd_data", 32'(cmd_data), 0);
      check("rst_mask", 32'(mask), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_err_bad_chan", 32'(err_bad_chan), 0);
      check("rst_err_no_ack", 32'(err_no_ack), 0);
      check("rst_err_timeout", 32'(err_timeout), 0);
      check("rst_frame_count", 32'(frame_count), 0);
      reset = 1'b0;
      tick(2);

      // Nominal load to channel 2
      send_frame(40'h2A_DEADBEEF, 0, 1'b1);
      wait_done();
      check("nom_frame_count", 32'(frame_count), 1);
      check("nom_err_no_ack", 32'(err_no_ack), 0);
      check("nom_err_bad_chan", 32'(err_bad_chan), 0);
      check("nom_err_timeout", 32'(err_timeout), 0);

      // Bad channel: dropped after CHECK, nothing strobed
      send_frame(40'h51_01020304, 0, 1'b0);
      check("bad_in_ready_check", 32'(in_ready), 0);
      tick(1);
      check("bad_in_ready_after", 32'(in_ready), 1);
      check("bad_err_bad_chan", 32'(err_bad_chan), 1);
      check("bad_busy", 32'(busy), 0);
      check("bad_frame_count", 32'(frame_count), 1);
      clear_pulse();
      check("bad_cleared", 32'(err_bad_chan), 0);

      // Set and clear in the same cycle: set wins
      send_frame(40'hF0_00000000, 0, 1'b0);
      clear_pulse();
      check("set_wins", 32'(err_bad_chan), 1);
      clear_pulse();
      check("set_wins_cleared", 32'(err_bad_chan), 0);

      // Busy channel: ack held for 10 cycles from CHECK delays the strobe by 10
      n0 = strobe_cyc.size();
      send_frame(40'h13_01020304, 0, 1'b1);
      c0 = cyc;
      force_ack[1] = 1'b1;
      tick(10);
      force_ack[1] = 1'b0;
      wait_done();
      check("busywait_strobe_seen", 32'(strobe_cyc.size()), 32'(n0 + 1));
      if (strobe_cyc.size() > n0) check("busywait_strobe_delay", 32'(strobe_cyc[n0] - c0), 11);
      check("busywait_frame_count", 32'(frame_count), 2);

      // Timeout: ack held far beyond WAIT_LIMIT
      n0 = strobe_cyc.size();
      force_ack[1] = 1'b1;
      send_frame(40'h17_CAFEF00D, 0, 1'b0);
      tick(250);
      check("timeout_not_yet", 32'(err_timeout), 0);
      check("timeout_still_busy", 32'(busy), 1);
      tick(50);
      check("timeout_err", 32'(err_timeout), 1);
      check("timeout_in_ready", 32'(in_ready), 1);
      check("timeout_busy", 32'(busy), 0);
      check("timeout_no_strobe", 32'(strobe_cyc.size()), 32'(n0));
      check("timeout_frame_count", 32'(frame_count), 2);
      force_ack[1] = 1'b0;
      clear_pulse();
      check("timeout_cleared", 32'(err_timeout), 0);

      // Missing ack from T+3: burst completes, frame not counted
      drop_at = 3;
      send_frame(40'h0C_11223344, 0, 1'b1);
      wait_done();
      drop_at = 6;
      check("noack_err", 32'(err_no_ack), 1);
      check("noack_frame_count", 32'(frame_count), 2);
      clear_pulse();
      check("noack_cleared", 32'(err_no_ack), 0);

      // Host stalls of 3 cycles between bytes
      send_frame(40'h35_12345678, 3, 1'b1);
      wait_done();
      check("stall_frame_count", 32'(frame_count), 3);

      // Back-to-back frames: strobes 12 cycles apart
      n0 = strobe_cyc.size();
      send_frame(40'h2F_01234567, 0, 1'b1);
      send_frame(40'h31_89ABCDEF, 0, 1'b1);
      wait_done();
      check("b2b_strobes", 32'(strobe_cyc.size()), 32'(n0 + 2));
      if (strobe_cyc.size() > n0 + 1) check("b2b_spacing", 32'(strobe_cyc[n0+1] - strobe_cyc[n0]), 12);
      check("b2b_frame_count", 32'(frame_count), 5);

      // Reset at T+2 of a burst
      mon_en = 1'b0;
      send_frame(40'h21_55AA55AA, 0, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (mask == '0 && n < 20);
      check("rstmid_strobe_seen", 32'(mask), 32'(N'(1) << 2));
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rstmid_t2_byte", 32'(cmd_data), 32'h0000_00AA);
      #1;
      reset = 1'b1;
      #1;
      check("rstmid_mask", 32'(mask), 0);
      check("rstmid_cmd_data", 32'(cmd_data), 0);
      check("rstmid_frame_count", 32'(frame_count), 0);
      check("rstmid_in_ready", 32'(in_ready), 1);
      tick(1);
      reset = 1'b0;
      tick(10);
      mon_en = 1'b1;

      // Frame after reset, with setting = 0
      send_frame(40'h10_00000001, 0, 1'b1);
      wait_done();
      check("post_rst_frame_count", 32'(frame_count), 1);
      check("post_rst_err_no_ack", 32'(err_no_ack), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
